// File: rtl/reg_select_pkg.sv
// Shared constants and helpers for the register select / scoreboard block.
package reg_select_pkg;

  localparam int unsigned DEF_NUM_REGS = 16;
  localparam int unsigned DEF_IR_W     = 32;
  localparam int unsigned DEF_RA_LSB   = 23;
  localparam int unsigned DEF_RB_LSB   = 19;
  localparam int unsigned DEF_RC_LSB   = 15;

  // Number of register-field selects asserted in one cycle.
  function automatic logic [1:0] gr_count(input logic gra, input logic grb, input logic grc);
    return 2'(gra) + 2'(grb) + 2'(grc);
  endfunction

endpackage

// File: rtl/reg_select_scoreboard_onehot_decoder.sv
// Combinational register index to one-hot enable decoder.
module onehot_decoder #(
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0]      idx,
  output logic [(1<<IDX_W)-1:0] onehot_c
);

  localparam int unsigned N = 1 << IDX_W;

  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) onehot_c[i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_select_scoreboard.sv
// Register field select, one-hot in/out enables and pending-write scoreboard.
// Optional macro SEL_R0_BASE_ZERO_EN: BAout on R0 reads constant zero via base_zero.
module reg_select_scoreboard
  import reg_select_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS),
  parameter int unsigned IR_W     = DEF_IR_W,
  parameter int unsigned RA_LSB   = DEF_RA_LSB,
  parameter int unsigned RB_LSB   = DEF_RB_LSB,
  parameter int unsigned RC_LSB   = DEF_RC_LSB
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                ir_load,
  input  logic [IR_W-1:0]     ir_in,
  input  logic                Gra,
  input  logic                Grb,
  input  logic                Grc,
  input  logic                Rin,
  input  logic                Rout,
  input  logic                BAout,
  input  logic                pend_set,
  input  logic                pend_clr,
  input  logic [IDX_W-1:0]    pend_clr_idx,
  output logic [NUM_REGS-1:0] register_ins,
  output logic [NUM_REGS-1:0] register_outs,
  output logic [IDX_W-1:0]    sel_idx,
  output logic                hazard,
`ifdef SEL_R0_BASE_ZERO_EN
  output logic                base_zero,
`endif
  output logic                sel_conflict
);

  logic [IR_W-1:0]     ir_q;
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_nxt;
  logic [IDX_W-1:0]    idx;
  logic                sel_valid;
  logic [NUM_REGS-1:0] sel_onehot;
  logic [NUM_REGS-1:0] ins_nxt;
  logic [NUM_REGS-1:0] outs_nxt;
  logic                read_req;
  logic                hazard_nxt;
  logic                ir_unused;
`ifdef SEL_R0_BASE_ZERO_EN
  logic                base_zero_nxt;
`endif

  // Only the register fields of the latched IR are consumed here.
  assign ir_unused = ^ir_q;

  // Fixed-priority field select: Ra over Rb over Rc.
  always_comb begin
    idx       = '0;
    sel_valid = 1'b0;
    if (Gra) begin
      idx       = ir_q[RA_LSB +: IDX_W];
      sel_valid = 1'b1;
    end else if (Grb) begin
      idx       = ir_q[RB_LSB +: IDX_W];
      sel_valid = 1'b1;
    end else if (Grc) begin
      idx       = ir_q[RC_LSB +: IDX_W];
      sel_valid = 1'b1;
    end
  end

  onehot_decoder #(.IDX_W(IDX_W)) u_dec (
    .idx      (idx),
    .onehot_c (sel_onehot)
  );

  always_comb begin
    read_req   = (Rout | BAout) & sel_valid;
    ins_nxt    = (Rin & sel_valid) ? sel_onehot : '0;
    outs_nxt   = read_req ? sel_onehot : '0;
    hazard_nxt = read_req & pend[idx];
`ifdef SEL_R0_BASE_ZERO_EN
    base_zero_nxt = BAout & sel_valid & (idx == '0);
    if (base_zero_nxt) outs_nxt[0] = 1'b0;
`endif
  end

  // Clear is applied before set so a same-index set wins.
  always_comb begin
    pend_nxt = pend;
    if (pend_clr) pend_nxt[pend_clr_idx] = 1'b0;
    if (pend_set && sel_valid) pend_nxt[idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      ir_q          <= '0;
      pend          <= '0;
      register_ins  <= '0;
      register_outs <= '0;
      sel_idx       <= '0;
      hazard        <= 1'b0;
      sel_conflict  <= 1'b0;
`ifdef SEL_R0_BASE_ZERO_EN
      base_zero     <= 1'b0;
`endif
    end else begin
      if (ir_load) ir_q <= ir_in;
      pend          <= pend_nxt;
      register_ins  <= ins_nxt;
      register_outs <= outs_nxt;
      sel_idx       <= idx;
      hazard        <= hazard_nxt;
      if (gr_count(Gra, Grb, Grc) >= 2'd2) sel_conflict <= 1'b1;
`ifdef SEL_R0_BASE_ZERO_EN
      base_zero     <= base_zero_nxt;
`endif
    end
  end

endmodule
